// File: rtl/recon_writer_luma4x4_pkg.sv
// Shared constants, FSM state type and frame geometry helpers for the luma 4x4 datapath.
package intra_pkg;

    localparam int unsigned LUMA_BLK = 4;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned MBNUM_W  = 13;
    localparam int unsigned WORD_PIX = 4;
    localparam int unsigned BLK_W    = LUMA_BLK * LUMA_BLK * PIX_W;
    localparam int unsigned WORD_W   = WORD_PIX * PIX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

    // 4x4 blocks per frame row.
    function automatic int unsigned calc_bpr(input int unsigned width);
        return width / LUMA_BLK;
    endfunction

    // 4x4 blocks per frame.
    function automatic int unsigned calc_num_blk(input int unsigned width,
                                                 input int unsigned length);
        return (length / LUMA_BLK) * calc_bpr(width);
    endfunction

endpackage

// File: rtl/recon_writer_luma4x4_if.sv
// Block input handshake, frame-buffer write port and status outputs of the recon writer.
interface recon_writer_luma4x4_if
    import intra_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
);
    logic                 in_valid;
    logic                 in_ready;
    logic [MBNUM_W-1:0]   mbnumber;
    logic [BLK_W-1:0]     blk;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [WORD_W-1:0]    mem_wdata;
    logic                 blk_done;
    logic                 frame_done;
    logic                 err;
    logic [MBNUM_W-1:0]   blk_count;

    modport slave (
        input  in_valid, mbnumber, blk,
        output in_ready, mem_we, mem_addr, mem_wdata, blk_done, frame_done, err, blk_count
    );

    modport master (
        output in_valid, mbnumber, blk,
        input  in_ready, mem_we, mem_addr, mem_wdata, blk_done, frame_done, err, blk_count
    );
endinterface

// File: rtl/recon_writer_luma4x4_addr_gen.sv
// Raster 4x4 block index -> word address of the block's top row, plus range check.
module luma4x4_addr_gen
    import intra_pkg::*;
#(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned LENGTH = 256,
    parameter int unsigned ADDR_W = 14
) (
    input  logic [MBNUM_W-1:0] i_mbnumber,
    output logic [ADDR_W-1:0]  o_base,
    output logic               o_in_range
);
    localparam int unsigned BPR     = calc_bpr(WIDTH);
    localparam int unsigned NUM_BLK = calc_num_blk(WIDTH, LENGTH);

    logic [31:0] w_m;
    logic [31:0] w_brow;
    logic [31:0] w_bcol;

    assign w_m    = 32'(i_mbnumber);
    assign w_brow = w_m / BPR;
    assign w_bcol = w_m % BPR;

    // Top row word address: (4*brow*WIDTH + 4*bcol)/4 = brow*WIDTH + bcol.
    assign o_base     = ADDR_W'(w_brow * WIDTH + w_bcol);
    assign o_in_range = (w_m < NUM_BLK);

endmodule

// File: rtl/recon_writer_luma4x4.sv
// Writes one reconstructed 4x4 luma block, a row per cycle, into the reconstructed frame buffer.
module recon_writer_luma4x4
    import intra_pkg::*;
#(
    parameter int unsigned LENGTH = 256,
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned ADDR_W = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    recon_writer_luma4x4_if.slave   bus
);
    localparam int unsigned BPR     = calc_bpr(WIDTH);
    localparam int unsigned NUM_BLK = calc_num_blk(WIDTH, LENGTH);

    wr_state_e            r_state;
    wr_state_e            w_state_d;
    logic [1:0]           r_row;
    logic [ADDR_W-1:0]    r_base;
    logic [BLK_W-1:0]     r_blk;
    logic                 r_last;
    logic                 r_err;
    logic [MBNUM_W-1:0]   r_blk_count;

    logic                 w_in_ready;
    logic                 w_hs;
    logic                 w_mem_we;
    logic                 w_blk_done;
    logic                 w_frame_done;
    logic [ADDR_W-1:0]    w_base;
    logic                 w_in_range;
    logic [ADDR_W-1:0]    w_row_off;

    luma4x4_addr_gen #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_mbnumber (bus.mbnumber),
        .o_base     (w_base),
        .o_in_range (w_in_range)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode and per-state control outputs.
    always_comb begin
        w_state_d    = r_state;
        w_in_ready   = 1'b0;
        w_hs         = 1'b0;
        w_mem_we     = 1'b0;
        w_blk_done   = 1'b0;
        w_frame_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_hs       = bus.in_valid;
                if (w_hs && w_in_range) begin
                    w_state_d = WRITE;
                end
            end
            WRITE: begin
                w_mem_we = 1'b1;
                if (r_row == 2'd3) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                w_blk_done   = 1'b1;
                w_frame_done = r_last;
                w_state_d    = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Block capture at handshake, row sequencing, error pulse and completed-block counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row       <= 2'd0;
            r_base      <= '0;
            r_blk       <= '0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_blk_count <= '0;
        end else begin
            r_err <= w_hs && !w_in_range;
            if (w_hs && w_in_range) begin
                r_blk  <= bus.blk;
                r_base <= w_base;
                r_last <= (32'(bus.mbnumber) == NUM_BLK - 1);
                r_row  <= 2'd0;
            end
            if (w_mem_we) begin
                r_row <= r_row + 2'd1;
            end
            // Count lands with the last row so it is visible alongside blk_done.
            if (w_mem_we && (r_row == 2'd3)) begin
                r_blk_count <= r_last ? '0 : r_blk_count + 1'b1;
            end
        end
    end

    assign w_row_off = ADDR_W'(32'(r_row) * BPR);

    assign bus.in_ready   = w_in_ready & ~reset;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_we ? (r_base + w_row_off) : '0;
    assign bus.mem_wdata  = w_mem_we ? r_blk[{r_row, 5'd0} +: WORD_W] : '0;
    assign bus.blk_done   = w_blk_done;
    assign bus.frame_done = w_frame_done;
    assign bus.err        = r_err;
    assign bus.blk_count  = r_blk_count;

endmodule

// File: tb/tb_recon_writer_luma4x4.sv
// Randomised scoreboard bench for recon_writer_luma4x4 (256x256 frame).
module tb_recon_writer_luma4x4;

    localparam int WIDTH   = 256;
    localparam int LENGTH  = 256;
    localparam int ADDR_W  = 14;
    localparam int BPR     = WIDTH / 4;
    localparam int NUM_BLK = (LENGTH / 4) * BPR;

    typedef struct {
        int          cyc;
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        logic        frame;
        logic [12:0] cnt;
    } done_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mcount = 0;

    wr_t   wq[$];
    done_t dq[$];
    int    eq[$];

    recon_writer_luma4x4_if #(.ADDR_W(ADDR_W)) bus ();

    recon_writer_luma4x4 #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: row j of block m sits at pixel row 4*brow+j, pixel column 4*bcol.
    function automatic logic [13:0] exp_addr(input int m, input int j);
        int brow;
        int bcol;
        brow = m / BPR;
        bcol = m % BPR;
        return 14'(((4 * brow + j) * WIDTH + 4 * bcol) / 4);
    endfunction

    function automatic logic [31:0] exp_data(input logic [127:0] b, input int j);
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            d[8*k +: 8] = b[8*(4*j+k) +: 8];
        end
        return d;
    endfunction

    // Present a block, wait for acceptance, record the expected response.
    task automatic send(input int m, input logic [127:0] b, output int t);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mbnumber = 13'(m);
        bus.blk      = b;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            t = -1;
            return;
        end
        @(posedge clk);
        #1;
        t = cyc;
        if (m >= NUM_BLK) begin
            eq.push_back(t);
        end else begin
            for (int j = 0; j < 4; j++) begin
                wr_t w;
                w.cyc  = t + j;
                w.addr = exp_addr(m, j);
                w.data = exp_data(b, j);
                wq.push_back(w);
            end
            begin
                done_t d;
                mcount  = (m == NUM_BLK - 1) ? 0 : mcount + 1;
                d.cyc   = t + 4;
                d.frame = (m == NUM_BLK - 1);
                d.cnt   = 13'(mcount);
                dq.push_back(d);
            end
        end
    endtask

    // Drop valid and put garbage on the data inputs for n cycles.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.mbnumber = 13'($urandom);
            bus.blk      = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: pop expectations whenever the DUT presents a write, completion or error.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 64'(bus.mem_addr), 64'hFFFF);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("write_cycle", 64'(cyc), 64'(w.cyc));
                chk("write_addr", 64'(bus.mem_addr), 64'(w.addr));
                chk("write_data", 64'(bus.mem_wdata), 64'(w.data));
            end
        end
        if (bus.blk_done) begin
            if (dq.size() == 0) begin
                chk("unexpected_blk_done", 64'(bus.blk_done), 64'd0);
            end else begin
                done_t d;
                d = dq.pop_front();
                chk("done_cycle", 64'(cyc), 64'(d.cyc));
                chk("frame_done", 64'(bus.frame_done), 64'(d.frame));
                chk("blk_count", 64'(bus.blk_count), 64'(d.cnt));
            end
        end else if (bus.frame_done) begin
            chk("frame_done_without_blk_done", 64'(bus.frame_done), 64'd0);
        end
        if (bus.err) begin
            if (eq.size() == 0) begin
                chk("unexpected_err", 64'(bus.err), 64'd0);
            end else begin
                int e;
                e = eq.pop_front();
                chk("err_cycle", 64'(cyc), 64'(e));
            end
        end
    end

    initial begin
        int t1;
        int t2;
        logic [127:0] ramp;
        for (int n = 0; n < 16; n++) ramp[8*n +: 8] = 8'(n);

        bus.in_valid = 1'b0;
        bus.mbnumber = '0;
        bus.blk      = '0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_blk_done", 64'(bus.blk_done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_blk_count", 64'(bus.blk_count), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);

        // Interior block, ramp pixels.
        send(65, ramp, t1);
        idle(7);
        // Last block of the frame: frame_done and count wrap.
        send(NUM_BLK - 1, rand_blk(), t1);
        idle(7);
        chk("count_after_wrap", 64'(bus.blk_count), 64'd0);
        // Out-of-range followed immediately by a valid block.
        send(NUM_BLK, rand_blk(), t1);
        send(0, rand_blk(), t2);
        chk("accept_after_err", 64'(t2 - t1), 64'd1);
        idle(7);
        // Back-to-back with valid held high.
        send(0, rand_blk(), t1);
        send(1, rand_blk(), t2);
        chk("back_to_back_spacing", 64'(t2 - t1), 64'd6);
        idle(7);

        // Random traffic, including out-of-range indices and variable gaps.
        for (int i = 0; i < 40; i++) begin
            int m;
            case ($urandom_range(0, 5))
                0: m = $urandom_range(NUM_BLK, 8191);
                1: m = NUM_BLK - 1;
                default: m = $urandom_range(0, NUM_BLK - 1);
            endcase
            send(m, rand_blk(), t1);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(8);

        // Reset during the second write cycle abandons the block.
        send(10, rand_blk(), t1);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        wq.delete();
        dq.delete();
        mcount = 0;
        @(negedge clk);
        chk("rst_mid_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_mid_blk_done", 64'(bus.blk_done), 64'd0);
        chk("rst_mid_blk_count", 64'(bus.blk_count), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid_no_write", 64'(bus.mem_we), 64'd0);
        chk("rst_mid_no_done", 64'(bus.blk_done), 64'd0);

        // Normal operation resumes with a fresh count.
        send(130, rand_blk(), t1);
        idle(10);
        chk("writes_drained", 64'(wq.size()), 64'd0);
        chk("dones_drained", 64'(dq.size()), 64'd0);
        chk("errs_drained", 64'(eq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
